alu_ctrl_decode: RTL and testbench

Decode-to-execute stage that produces the `ALU_Control` code and both ALU operands for the shared execute-stage ALU. It takes a fetched RV32I instruction plus register-file read data, and registers the result into the ID/EX boundary. It also handles pipeline stall and flush. It is the producer side of the ALU control/operand interface; the ALU itself stays purely combinational.

---
 rtl/alu_ctrl_decode.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_alu_ctrl_decode.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: RV32I decode into the ID/EX ALU control and operand registers.
// Optional feature macro ALU_CTRL_ILLEGAL_EN: forward illegal encodings flagged on ex_illegal.

`ifndef ADD
`define ADD  6'd0
`endif
`ifndef SUB
`define SUB  6'd1
`endif
`ifndef SLL
`define SLL  6'd2
`endif
`ifndef SLT
`define SLT  6'd3
`endif
`ifndef SLTU
`define SLTU 6'd4
`endif
`ifndef XOR
`define XOR  6'd5
`endif
`ifndef SRL
`define SRL  6'd6
`endif
`ifndef SRA
`define SRA  6'd7
`endif
`ifndef OR
`define OR   6'd8
`endif
`ifndef AND
`define AND  6'd9
`endif
`ifndef JAL
`define JAL  6'd10
`endif
`ifndef JALR
`define JALR 6'd11
`endif
`ifndef BEQ
`define BEQ  6'd12
`endif
`ifndef BNE
`define BNE  6'd13
`endif
`ifndef BLT
`define BLT  6'd14
`endif
`ifndef BGE
`define BGE  6'd15
`endif
`ifndef BLTU
`define BLTU 6'd16
`endif
`ifndef BGEU
`define BGEU 6'd17
`endif

module alu_ctrl_decode #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instruction,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic [XLEN-1:0] store_data,
    output logic            ex_branch,
    output logic            ex_illegal
);

    localparam int unsigned CTRL_W  = 6;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields and immediates
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt_imm;
    logic [XLEN-1:0] shamt_reg;
    logic [XLEN-1:0] pc_plus4;

    assign opcode    = id_instruction[6:0];
    assign funct3    = id_instruction[14:12];
    assign funct7    = id_instruction[31:25];
    assign imm_i     = {{20{id_instruction[31]}}, id_instruction[31:20]};
    assign imm_s     = {{20{id_instruction[31]}}, id_instruction[31:25], id_instruction[11:7]};
    assign imm_u     = {id_instruction[31:12], 12'b0};
    assign shamt_imm = {{(XLEN-SHAMT_W){1'b0}}, id_instruction[24:20]};
    assign shamt_reg = {{(XLEN-SHAMT_W){1'b0}}, rs2_data[4:0]};
    assign pc_plus4  = id_pc + XLEN'(4);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic [XLEN-1:0]   dec_sd;
    logic              dec_br;
    logic              dec_ill;

    // Combinational decode of the instruction currently on id_*
    always_comb begin
        dec_ctrl = `ADD;
        dec_a    = '0;
        dec_b    = '0;
        dec_sd   = '0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = id_pc;
                dec_b = imm_u;
            end
            OPC_JAL: begin
                dec_ctrl = `JAL;
                dec_a    = pc_plus4;
            end
            OPC_JALR: begin
                dec_ctrl = `JALR;
                dec_a    = pc_plus4;
            end
            OPC_BRANCH: begin
                dec_a  = rs1_data;
                dec_b  = rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl = `BEQ;
                    3'b001:  dec_ctrl = `BNE;
                    3'b100:  dec_ctrl = `BLT;
                    3'b101:  dec_ctrl = `BGE;
                    3'b110:  dec_ctrl = `BLTU;
                    3'b111:  dec_ctrl = `BGEU;
                    default: dec_ill  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_a = rs1_data;
                dec_b = imm_i;
            end
            OPC_STORE: begin
                dec_a  = rs1_data;
                dec_b  = imm_s;
                dec_sd = rs2_data;
            end
            OPC_OPIMM: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_ctrl = `ADD;
                    3'b010: dec_ctrl = `SLT;
                    3'b011: dec_ctrl = `SLTU;
                    3'b100: dec_ctrl = `XOR;
                    3'b110: dec_ctrl = `OR;
                    3'b111: dec_ctrl = `AND;
                    3'b001: begin
                        dec_ctrl = `SLL;
                        dec_b    = shamt_imm;
                        dec_ill  = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_b = shamt_imm;
                        if (funct7 == F7_BASE) begin
                            dec_ctrl = `SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_ctrl = `SRA;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                dec_a = rs1_data;
                // The ALU shifts by all of operand B, so register shifts are masked here
                dec_b = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? shamt_reg : rs2_data;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec_ctrl = `ADD;
                        3'b001:  dec_ctrl = `SLL;
                        3'b010:  dec_ctrl = `SLT;
                        3'b011:  dec_ctrl = `SLTU;
                        3'b100:  dec_ctrl = `XOR;
                        3'b101:  dec_ctrl = `SRL;
                        3'b110:  dec_ctrl = `OR;
                        default: dec_ctrl = `AND;
                    endcase
                end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
                    dec_ctrl = `SUB;
                end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
                    dec_ctrl = `SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase

        // Illegal encodings present a harmless ADD 0,0 to the ALU
        if (dec_ill) begin
            dec_ctrl = `ADD;
            dec_a    = '0;
            dec_b    = '0;
            dec_sd   = '0;
            dec_br   = 1'b0;
        end
    end

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   sd_q, sd_d;
    logic              br_q, br_d;
    logic              ill_q, ill_d;
    logic              load_bubble;

`ifdef ALU_CTRL_ILLEGAL_EN
    assign load_bubble = ~id_valid;
`else
    assign load_bubble = ~id_valid | dec_ill;
`endif

    // Next-state: flush beats stall beats load; bubbles load reset values
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        br_d    = br_q;
        ill_d   = ill_q;

        if (flush || (!stall && load_bubble)) begin
            valid_d = 1'b0;
            ctrl_d  = `ADD;
            a_d     = '0;
            b_d     = '0;
            sd_d    = '0;
            br_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (!stall) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            a_d     = dec_a;
            b_d     = dec_b;
            sd_d    = dec_sd;
            br_d    = dec_br;
`ifdef ALU_CTRL_ILLEGAL_EN
            ill_d   = dec_ill;
`else
            ill_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= `ADD;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ALU_Control = ctrl_q;
    assign operand_A   = a_q;
    assign operand_B   = b_q;
    assign store_data  = sd_q;
    assign ex_branch   = br_q;
`ifdef ALU_CTRL_ILLEGAL_EN
    assign ex_illegal  = ill_q;
`else
    assign ex_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: table-driven and sequence checks of the ID/EX ALU control decode stage.
// Honours ALU_CTRL_ILLEGAL_EN the same way the design does.
module tb_alu_ctrl_decode;

    localparam logic [5:0] C_ADD  = 6'd0;
    localparam logic [5:0] C_SUB  = 6'd1;
    localparam logic [5:0] C_SLL  = 6'd2;
    localparam logic [5:0] C_SLTU = 6'd4;
    localparam logic [5:0] C_XOR  = 6'd5;
    localparam logic [5:0] C_SRA  = 6'd7;
    localparam logic [5:0] C_AND  = 6'd9;
    localparam logic [5:0] C_JAL  = 6'd10;
    localparam logic [5:0] C_JALR = 6'd11;
    localparam logic [5:0] C_BEQ  = 6'd12;
    localparam logic [5:0] C_BGE  = 6'd15;
    localparam logic [5:0] C_BLTU = 6'd16;

`ifdef ALU_CTRL_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic        br;
        logic        ill;
    } out_t;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        out_t        exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instruction = 32'h0;
    logic [31:0] id_pc = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] store_data;
    logic        ex_branch;
    logic        ex_illegal;

    int   n_checks = 0;
    int   n_errors = 0;
    out_t sb_q[$];
    vec_t vecs[$];

    alu_ctrl_decode #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_pc(id_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ALU_Control(ALU_Control),
        .operand_A(operand_A), .operand_B(operand_B), .store_data(store_data),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic out_t o(logic v, logic [5:0] c, logic [31:0] a, logic [31:0] b,
                               logic [31:0] sd, logic br, logic il);
        out_t r;
        r.valid = v; r.ctrl = c; r.a = a; r.b = b; r.sd = sd; r.br = br; r.ill = il;
        return r;
    endfunction

    function automatic out_t zero_out();
        return o(1'b0, C_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic out_t ill_out();
        return o(ILL, C_ADD, 32'h0, 32'h0, 32'h0, 1'b0, ILL);
    endfunction

    function automatic vec_t mk(string n, logic v, logic [31:0] ins, logic [31:0] pc,
                                logic [31:0] r1, logic [31:0] r2, out_t e);
        vec_t t;
        t.name = n; t.valid = v; t.instr = ins; t.pc = pc; t.rs1 = r1; t.rs2 = r2; t.exp = e;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid       = t.valid;
        id_instruction = t.instr;
        id_pc          = t.pc;
        rs1_data       = t.rs1;
        rs2_data       = t.rs2;
    endtask

    // Pop the oldest expected record and compare it to the sampled outputs
    task automatic check(input string name);
        out_t act;
        out_t exp;
        act = {ex_valid, ALU_Control, operand_A, operand_B, store_data, ex_branch, ex_illegal};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        exp = sb_q.pop_front();
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got v=%b c=%0d a=%h b=%h sd=%h br=%b il=%b, want v=%b c=%0d a=%h b=%h sd=%h br=%b il=%b",
                     name, act.valid, act.ctrl, act.a, act.b, act.sd, act.br, act.ill,
                     exp.valid, exp.ctrl, exp.a, exp.b, exp.sd, exp.br, exp.ill);
        end
    endtask

    task automatic step(input vec_t t, input logic st, input logic fl, input out_t e);
        @(negedge clock);
        drive(t);
        stall = st;
        flush = fl;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        check(t.name);
    endtask

    vec_t v_addi, v_sub, v_lui;

    initial begin
        v_addi = mk("addi_x1_x0_5", 1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0,
                    o(1'b1, C_ADD, 32'h0, 32'h5, 32'h0, 1'b0, 1'b0));
        v_sub  = mk("sub", 1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4,
                    o(1'b1, C_SUB, 32'd9, 32'd4, 32'h0, 1'b0, 1'b0));
        v_lui  = mk("lui", 1'b1, 32'h123452B7, 32'h0, 32'h55, 32'h66,
                    o(1'b1, C_ADD, 32'h0, 32'h12345000, 32'h0, 1'b0, 1'b0));

        vecs.push_back(v_addi);
        vecs.push_back(mk("addi_neg", 1'b1, 32'hFFF10093, 32'h0, 32'd10, 32'h0,
                          o(1'b1, C_ADD, 32'd10, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(v_sub);
        vecs.push_back(mk("sra_reg_mask", 1'b1, 32'h4020D1B3, 32'h0, 32'h80000000, 32'h25,
                          o(1'b1, C_SRA, 32'h80000000, 32'h5, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("sll_reg_mask", 1'b1, 32'h002091B3, 32'h0, 32'h1, 32'hFFFFFFE3,
                          o(1'b1, C_SLL, 32'h1, 32'h3, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("sltu_reg", 1'b1, 32'h0020B1B3, 32'h0, 32'h3, 32'h7,
                          o(1'b1, C_SLTU, 32'h3, 32'h7, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("and_reg", 1'b1, 32'h0020F1B3, 32'h0, 32'hF0F0, 32'h0FF0,
                          o(1'b1, C_AND, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(v_lui);
        vecs.push_back(mk("auipc", 1'b1, 32'hFFFFF297, 32'h100, 32'h1, 32'h2,
                          o(1'b1, C_ADD, 32'h100, 32'hFFFFF000, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("jal_wrap", 1'b1, 32'h000000EF, 32'hFFFFFFFC, 32'h1, 32'h2,
                          o(1'b1, C_JAL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("jalr", 1'b1, 32'h000100E7, 32'h1000, 32'h7, 32'h8,
                          o(1'b1, C_JALR, 32'h1004, 32'h0, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("bltu", 1'b1, 32'h0020E463, 32'h0, 32'h11, 32'h22,
                          o(1'b1, C_BLTU, 32'h11, 32'h22, 32'h0, 1'b1, 1'b0)));
        vecs.push_back(mk("beq", 1'b1, 32'h00208063, 32'h0, 32'h5, 32'h5,
                          o(1'b1, C_BEQ, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0)));
        vecs.push_back(mk("bge", 1'b1, 32'h0020D063, 32'h0, 32'hFFFFFFFF, 32'h1,
                          o(1'b1, C_BGE, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0)));
        vecs.push_back(mk("branch_f3_010", 1'b1, 32'h0020A063, 32'h0, 32'h5, 32'h6, ill_out()));
        vecs.push_back(mk("lw_neg", 1'b1, 32'hFFC0A183, 32'h0, 32'h2000, 32'h9,
                          o(1'b1, C_ADD, 32'h2000, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("sw_pos", 1'b1, 32'h0020A423, 32'h0, 32'h3000, 32'hCAFEBABE,
                          o(1'b1, C_ADD, 32'h3000, 32'h8, 32'hCAFEBABE, 1'b0, 1'b0)));
        vecs.push_back(mk("sw_neg", 1'b1, 32'hFE20A823, 32'h0, 32'h3000, 32'h12345678,
                          o(1'b1, C_ADD, 32'h3000, 32'hFFFFFFF0, 32'h12345678, 1'b0, 1'b0)));
        vecs.push_back(mk("slli_31", 1'b1, 32'h01F11093, 32'h0, 32'h1, 32'hFFFFFFFF,
                          o(1'b1, C_SLL, 32'h1, 32'd31, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("srai_4", 1'b1, 32'h40415093, 32'h0, 32'h80000000, 32'h0,
                          o(1'b1, C_SRA, 32'h80000000, 32'd4, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("srli_bad_f7", 1'b1, 32'h20415093, 32'h0, 32'h1, 32'h2, ill_out()));
        vecs.push_back(mk("slli_bad_f7", 1'b1, 32'h40411093, 32'h0, 32'h1, 32'h2, ill_out()));
        vecs.push_back(mk("sltiu_1", 1'b1, 32'h00113093, 32'h0, 32'h0, 32'h0,
                          o(1'b1, C_SLTU, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("xori_m1", 1'b1, 32'hFFF14093, 32'h0, 32'hA5A5A5A5, 32'h0,
                          o(1'b1, C_XOR, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0)));
        vecs.push_back(mk("opcode_7f", 1'b1, 32'h0000007F, 32'h0, 32'h1, 32'h2, ill_out()));
        vecs.push_back(mk("op_alt_f3_111", 1'b1, 32'h4020F1B3, 32'h0, 32'h1, 32'h2, ill_out()));
        vecs.push_back(mk("bubble_valid0", 1'b0, 32'h00500093, 32'h0, 32'h1, 32'h2, zero_out()));

        // Reset state, before any clock edge
        #2;
        sb_q.push_back(zero_out());
        check("reset_state");
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) step(vecs[i], 1'b0, 1'b0, vecs[i].exp);

        // Stall holds for three cycles while id_* changes
        step(v_addi, 1'b0, 1'b0, v_addi.exp);
        step(v_sub, 1'b1, 1'b0, v_addi.exp);
        step(v_lui, 1'b1, 1'b0, v_addi.exp);
        step(vecs[24], 1'b1, 1'b0, v_addi.exp);
        // Flush wins over stall
        step(v_sub, 1'b1, 1'b1, zero_out());
        step(v_sub, 1'b0, 1'b0, v_sub.exp);
        // Stall ignores id_valid=0 on the inputs
        step(vecs[26], 1'b1, 1'b0, v_sub.exp);
        // Flush alone kills a valid load
        step(v_addi, 1'b0, 1'b1, zero_out());
        step(v_addi, 1'b0, 1'b0, v_addi.exp);

        // Asynchronous reset between clock edges while stalled with a live instruction
        step(v_lui, 1'b0, 1'b0, v_lui.exp);
        step(v_sub, 1'b1, 1'b0, v_lui.exp);
        #1;
        reset_n = 1'b0;
        #1;
        sb_q.push_back(zero_out());
        check("async_reset_mid_stall");
        @(negedge clock);
        reset_n = 1'b1;
        step(v_sub, 1'b0, 1'b0, v_sub.exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
